ntt_intt_ip_bf_sched: RTL and testbench

//  Butterfly scheduler for the Kyber NTT/INTT datapath (n=256, 7 layers x 128 butterflies).

---
 rtl/ntt_intt_ip_bf_sched.sv | 232 +++++++++++++++++++++++
 tb/tb_ntt_intt_ip_bf_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_intt_ip_bf_sched.sv
// ntt_intt_ip_bf_sched
//   Butterfly scheduler for the Kyber NTT/INTT datapath (n=256, 7 layers x 128
//   butterflies). On start it walks every butterfly of every layer. It issues one
//   (addr_a, addr_b, zeta_idx) triple per valid/ready handshake. It tracks how many
//   butterflies are in flight in the datapath. Between layers it holds a RAW barrier
//   until every issued butterfly has retired.
//
// Optional feature (compile-time macro NTT_INTT_SCHED_SCALE_EN):
//   When the macro is defined, an INTT run appends a scaling pass as layer 7. This pass
//   issues 128 ops (j, j+128, zeta 0) with bf_scale_o=1. When the macro is not defined,
//   INTT stops after layer 6 and bf_scale_o stays 0.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   start_i, mode_i     start pulse (IDLE only); mode 0=NTT, 1=INTT, sampled with start
//   abort_i             synchronous abort back to IDLE
//   bf_valid_o/ready_i  butterfly request handshake
//   bf_addr_a_o/_b_o    lower / upper coefficient address
//   bf_zeta_idx_o       twiddle ROM index
//   bf_mode_o           latched mode for the datapath
//   bf_scale_o          request is an INTT final-scaling op
//   dp_ret_i            one butterfly retired this cycle
//   layer_o             current layer (7 = scale pass)
//   busy_o, done_o      status; done_o is a one-cycle pulse
//   err_o               sticky: retire seen with nothing outstanding
module ntt_intt_ip_bf_sched #(
  parameter int ADDR_W  = 8,
  parameter int ZIDX_W  = 7,
  parameter int MAX_OUT = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic              abort_i,
  output logic              bf_valid_o,
  input  logic              bf_ready_i,
  output logic [ADDR_W-1:0] bf_addr_a_o,
  output logic [ADDR_W-1:0] bf_addr_b_o,
  output logic [ZIDX_W-1:0] bf_zeta_idx_o,
  output logic              bf_mode_o,
  output logic              bf_scale_o,
  input  logic              dp_ret_i,
  output logic [2:0]        layer_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BARRIER,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [6:0]        bf_q;      // handshakes completed in the current layer
  logic [OUT_W-1:0]  out_q;     // issued but not yet retired
  logic [OUT_W-1:0]  drain_q;   // retires still owed by an aborted run

  logic              hs, ret_eff, spurious, drain_ret, can_issue;
  logic [OUT_W-1:0]  out_nxt;
  logic [2:0]        last_layer;

  // Request generator inputs: chosen so the generator always describes the
  // request that is about to be loaded into the output registers.
  logic              gen_mode;
  logic [2:0]        gen_layer;
  logic [6:0]        gen_idx;
  logic [2:0]        sh;
  logic [ADDR_W-1:0] b_ext, len, g, o;
  logic [ADDR_W-1:0] gen_a, gen_b;
  logic [ZIDX_W-1:0] gen_zeta;
  logic              gen_scale;

  always_comb begin
    hs        = bf_valid_o && bf_ready_i;
    ret_eff   = dp_ret_i && (out_q != '0);
    drain_ret = dp_ret_i && (out_q == '0) && (drain_q != '0);
    spurious  = dp_ret_i && (out_q == '0) && (drain_q == '0);
    out_nxt   = out_q + OUT_W'(hs) - OUT_W'(ret_eff);
    can_issue = out_nxt < OUT_W'(MAX_OUT);
`ifdef NTT_INTT_SCHED_SCALE_EN
    last_layer = bf_mode_o ? 3'd7 : 3'd6;
`else
    last_layer = 3'd6;
`endif
  end

  always_comb begin
    gen_mode  = bf_mode_o;
    gen_layer = layer_o;
    gen_idx   = bf_q + 7'(hs);
    if (state_q == S_IDLE) begin
      gen_mode  = mode_i;
      gen_layer = 3'd0;
      gen_idx   = 7'd0;
    end else if (state_q == S_BARRIER) begin
      gen_layer = layer_o + 3'd1;
      gen_idx   = 7'd0;
    end

    // sh = log2(len): NTT len=128>>l, INTT len=2<<l.
    sh        = gen_mode ? (gen_layer + 3'd1) : (3'd7 - gen_layer);
    b_ext     = ADDR_W'(gen_idx);
    len       = ADDR_W'(1) << sh;
    g         = b_ext >> sh;
    o         = b_ext & (len - ADDR_W'(1));
    gen_a     = (g << ({1'b0, sh} + 4'd1)) | o;
    gen_b     = gen_a + len;
    gen_zeta  = gen_mode ? ZIDX_W'((ADDR_W'(128) >> gen_layer) - ADDR_W'(1) - g)
                         : ((ZIDX_W'(1) << gen_layer) + ZIDX_W'(g));
    gen_scale = 1'b0;
`ifdef NTT_INTT_SCHED_SCALE_EN
    if (gen_layer == 3'd7) begin
      gen_a     = b_ext;
      gen_b     = b_ext + ADDR_W'(128);
      gen_zeta  = '0;
      gen_scale = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      bf_q          <= '0;
      out_q         <= '0;
      drain_q       <= '0;
      bf_valid_o    <= 1'b0;
      bf_addr_a_o   <= '0;
      bf_addr_b_o   <= '0;
      bf_zeta_idx_o <= '0;
      bf_mode_o     <= 1'b0;
      bf_scale_o    <= 1'b0;
      layer_o       <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (spurious)  err_o   <= 1'b1;
      if (drain_ret) drain_q <= drain_q - OUT_W'(1);

      case (state_q)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            state_q       <= S_ISSUE;
            bf_mode_o     <= mode_i;
            layer_o       <= '0;
            bf_q          <= '0;
            out_q         <= '0;
            // A new run assumes the datapath has been flushed.
            drain_q       <= '0;
            err_o         <= 1'b0;
            busy_o        <= 1'b1;
            bf_valid_o    <= 1'b1;
            bf_addr_a_o   <= gen_a;
            bf_addr_b_o   <= gen_b;
            bf_zeta_idx_o <= gen_zeta;
            bf_scale_o    <= gen_scale;
          end
        end

        S_ISSUE: begin
          out_q <= out_nxt;
          if (hs) bf_q <= bf_q + 7'd1;
          if (hs && bf_q == 7'd127) begin
            bf_valid_o <= 1'b0;
            state_q    <= S_BARRIER;
          end else if (bf_valid_o && !hs) begin
            // Unaccepted request: hold every bf_* output.
          end else if (can_issue) begin
            bf_valid_o    <= 1'b1;
            bf_addr_a_o   <= gen_a;
            bf_addr_b_o   <= gen_b;
            bf_zeta_idx_o <= gen_zeta;
            bf_scale_o    <= gen_scale;
          end else begin
            bf_valid_o <= 1'b0;
          end
        end

        S_BARRIER: begin
          out_q <= out_nxt;
          // Using out_nxt means done_o (or the next layer's first request) appears
          // the cycle right after the final retire is sampled.
          if (out_nxt == '0) begin
            if (layer_o == last_layer) begin
              state_q <= S_DONE;
              done_o  <= 1'b1;
            end else begin
              state_q       <= S_ISSUE;
              layer_o       <= layer_o + 3'd1;
              bf_q          <= '0;
              bf_valid_o    <= 1'b1;
              bf_addr_a_o   <= gen_a;
              bf_addr_b_o   <= gen_b;
              bf_zeta_idx_o <= gen_zeta;
              bf_scale_o    <= gen_scale;
            end
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_o  <= 1'b0;
          layer_o <= '0;
        end

        default: state_q <= S_IDLE;
      endcase

      if (abort_i && state_q != S_IDLE) begin
        state_q    <= S_IDLE;
        bf_valid_o <= 1'b0;
        bf_scale_o <= 1'b0;
        busy_o     <= 1'b0;
        done_o     <= 1'b0;
        layer_o    <= '0;
        bf_q       <= '0;
        out_q      <= '0;
        // Butterflies already in the datapath will still retire; absorb them silently.
        drain_q    <= out_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ntt_intt_ip_bf_sched.sv
module tb_ntt_intt_ip_bf_sched;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start_i = 1'b0;
  logic       mode_i = 1'b0;
  logic       abort_i = 1'b0;
  logic       bf_ready_i = 1'b0;
  logic       dp_ret_i = 1'b0;
  logic       bf_valid_o;
  logic [7:0] bf_addr_a_o;
  logic [7:0] bf_addr_b_o;
  logic [6:0] bf_zeta_idx_o;
  logic       bf_mode_o;
  logic       bf_scale_o;
  logic [2:0] layer_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  always #5 clk_i = ~clk_i;

  ntt_intt_ip_bf_sched #(.ADDR_W(8), .ZIDX_W(7), .MAX_OUT(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i), .abort_i(abort_i),
    .bf_valid_o(bf_valid_o), .bf_ready_i(bf_ready_i), .bf_addr_a_o(bf_addr_a_o),
    .bf_addr_b_o(bf_addr_b_o), .bf_zeta_idx_o(bf_zeta_idx_o), .bf_mode_o(bf_mode_o),
    .bf_scale_o(bf_scale_o), .dp_ret_i(dp_ret_i), .layer_o(layer_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );

  int passed = 0;
  int total  = 0;

  // Environment controls
  bit auto_ret = 0;  // datapath model retires each request 4 cycles after issue
  bit man_ret  = 0;
  bit rdy_rand = 0;
  bit rdy_val  = 1;

  // Recorded activity
  int rq_a [0:1099];
  int rq_b [0:1099];
  int rq_k [0:1099];
  bit rq_s [0:1099];
  int n_req, done_cnt, scale_cnt, stall_viol, stall_cycles, max_layer;
  int cyc, last_ret_cyc, done_cyc;
  bit hs_last, stall_prev;
  logic [7:0] pa, pb;
  logic [6:0] pk;
  logic       ps;
  logic [3:0] pipe = '0;

  always @(negedge clk_i) begin
    cyc++;
    if (rst_ni) begin
      if (stall_prev) begin
        if (!bf_valid_o || bf_addr_a_o !== pa || bf_addr_b_o !== pb ||
            bf_zeta_idx_o !== pk || bf_scale_o !== ps)
          stall_viol++;
      end
      stall_prev = bf_valid_o && !bf_ready_i;
      if (stall_prev) stall_cycles++;
      pa = bf_addr_a_o; pb = bf_addr_b_o; pk = bf_zeta_idx_o; ps = bf_scale_o;
      if (bf_valid_o && bf_ready_i) begin
        if (n_req < 1100) begin
          rq_a[n_req] = bf_addr_a_o;
          rq_b[n_req] = bf_addr_b_o;
          rq_k[n_req] = bf_zeta_idx_o;
          rq_s[n_req] = bf_scale_o;
        end
        n_req++;
        if (bf_scale_o) scale_cnt++;
      end
      if (dp_ret_i) last_ret_cyc = cyc;
      if (done_o) begin done_cnt++; done_cyc = cyc; end
      if (int'(layer_o) > max_layer) max_layer = layer_o;
      hs_last = bf_valid_o && bf_ready_i;
    end else begin
      stall_prev = 0;
      hs_last    = 0;
    end
  end

  always @(posedge clk_i) begin
    #1;
    pipe       = {pipe[2:0], hs_last};
    dp_ret_i   = (auto_ret && pipe[3]) || man_ret;
    bf_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference request for global request number n of a run.
  function automatic void model_req(input bit m, input int n,
                                    output int a, output int b, output int k, output bit s);
    int l, bi, len, g, o;
    l  = n / 128;
    bi = n % 128;
    if (l == 7) begin
      a = bi; b = bi + 128; k = 0; s = 1;
    end else begin
      len = m ? (2 << l) : (128 >> l);
      g   = bi / len;
      o   = bi % len;
      a   = 2 * len * g + o;
      b   = a + len;
      k   = m ? ((128 >> l) - 1 - g) : ((1 << l) + g);
      s   = 0;
    end
  endfunction

  task automatic clear_rec();
    n_req = 0; done_cnt = 0; scale_cnt = 0; stall_viol = 0; stall_cycles = 0;
    max_layer = 0; last_ret_cyc = -100; done_cyc = -1;
  endtask

  task automatic do_start(input bit m);
    @(negedge clk_i); mode_i = m; start_i = 1;
    @(negedge clk_i); start_i = 0;
  endtask

  task automatic do_abort();
    @(negedge clk_i); abort_i = 1;
    @(negedge clk_i); abort_i = 0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (done_cnt > 0) begin ok = 1; break; end
    end
    repeat (6) @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_ni = 0;
    repeat (3) @(negedge clk_i);
    total++; if (bf_valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bf_valid_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_o); else passed++;
    total++; if ({done_o, err_o} !== 2'b00) $display("FAIL reset_done_err: got %b expected 00", {done_o, err_o}); else passed++;
    total++; if (layer_o !== 3'd0) $display("FAIL reset_layer: got %0d expected 0", layer_o); else passed++;
    total++; if ({bf_addr_a_o, bf_addr_b_o, bf_zeta_idx_o, bf_mode_o, bf_scale_o} !== 25'd0)
      $display("FAIL reset_bf_fields: got a=%0d b=%0d k=%0d m=%b s=%b expected all 0",
               bf_addr_a_o, bf_addr_b_o, bf_zeta_idx_o, bf_mode_o, bf_scale_o);
    else passed++;
    rst_ni = 1;
    repeat (3) @(negedge clk_i);
  endtask

  task automatic test_ntt();
    bit ok;
    int mism, first, ea, eb, ek;
    bit es;
    clear_rec(); auto_ret = 1; rdy_rand = 0; rdy_val = 1;
    do_start(0);
    total++; if (bf_valid_o !== 1'b1 || busy_o !== 1'b1)
      $display("FAIL ntt_valid_after_start: got valid=%b busy=%b expected 1 1", bf_valid_o, busy_o);
    else passed++;
    wait_done(3000, ok);
    total++; if (ok !== 1'b1) $display("FAIL ntt_done_timeout: got %b expected 1", ok); else passed++;
    total++; if (n_req !== 896) $display("FAIL ntt_req_count: got %0d expected 896", n_req); else passed++;
    total++; if (rq_a[0] !== 0 || rq_b[0] !== 128 || rq_k[0] !== 1)
      $display("FAIL ntt_first_req: got (%0d,%0d,%0d) expected (0,128,1)", rq_a[0], rq_b[0], rq_k[0]);
    else passed++;
    total++; if (rq_a[128] !== 0 || rq_b[128] !== 64 || rq_k[128] !== 2)
      $display("FAIL ntt_layer1_first: got (%0d,%0d,%0d) expected (0,64,2)", rq_a[128], rq_b[128], rq_k[128]);
    else passed++;
    total++; if (rq_a[895] !== 253 || rq_b[895] !== 255 || rq_k[895] !== 127)
      $display("FAIL ntt_last_req: got (%0d,%0d,%0d) expected (253,255,127)", rq_a[895], rq_b[895], rq_k[895]);
    else passed++;
    mism = 0; first = -1;
    for (int i = 0; i < 896 && i < n_req; i++) begin
      model_req(0, i, ea, eb, ek, es);
      if (rq_a[i] != ea || rq_b[i] != eb || rq_k[i] != ek || rq_s[i] != es) begin
        mism++; if (first < 0) first = i;
      end
    end
    total++; if (mism !== 0) $display("FAIL ntt_sequence: got %0d mismatches (first at %0d) expected 0", mism, first); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL ntt_done_count: got %0d expected 1", done_cnt); else passed++;
    total++; if (done_cyc !== last_ret_cyc + 1)
      $display("FAIL ntt_done_latency: got done at %0d, last retire at %0d, expected one cycle later", done_cyc, last_ret_cyc);
    else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL ntt_busy_after_done: got %b expected 0", busy_o); else passed++;
  endtask

  task automatic test_intt();
    bit ok;
    int mism, first, ea, eb, ek, n_exp, sc_exp, ml_exp;
    bit es;
`ifdef NTT_INTT_SCHED_SCALE_EN
    n_exp = 1024; sc_exp = 128; ml_exp = 7;
`else
    n_exp = 896; sc_exp = 0; ml_exp = 6;
`endif
    clear_rec(); auto_ret = 1; rdy_rand = 0; rdy_val = 1;
    do_start(1);
    wait_done(3500, ok);
    total++; if (ok !== 1'b1) $display("FAIL intt_done_timeout: got %b expected 1", ok); else passed++;
    total++; if (n_req !== n_exp) $display("FAIL intt_req_count: got %0d expected %0d", n_req, n_exp); else passed++;
    total++; if (rq_a[0] !== 0 || rq_b[0] !== 2 || rq_k[0] !== 127)
      $display("FAIL intt_first_req: got (%0d,%0d,%0d) expected (0,2,127)", rq_a[0], rq_b[0], rq_k[0]);
    else passed++;
    total++; if (rq_a[895] !== 127 || rq_b[895] !== 255 || rq_k[895] !== 1)
      $display("FAIL intt_layer6_last: got (%0d,%0d,%0d) expected (127,255,1)", rq_a[895], rq_b[895], rq_k[895]);
    else passed++;
    total++; if (scale_cnt !== sc_exp) $display("FAIL intt_scale_count: got %0d expected %0d", scale_cnt, sc_exp); else passed++;
    total++; if (max_layer !== ml_exp) $display("FAIL intt_max_layer: got %0d expected %0d", max_layer, ml_exp); else passed++;
`ifdef NTT_INTT_SCHED_SCALE_EN
    total++; if (rq_a[896] !== 0 || rq_b[896] !== 128 || rq_k[896] !== 0 || rq_s[896] !== 1'b1)
      $display("FAIL intt_scale_first: got (%0d,%0d,%0d,s=%b) expected (0,128,0,s=1)", rq_a[896], rq_b[896], rq_k[896], rq_s[896]);
    else passed++;
    total++; if (rq_a[1023] !== 127 || rq_b[1023] !== 255 || rq_k[1023] !== 0)
      $display("FAIL intt_scale_last: got (%0d,%0d,%0d) expected (127,255,0)", rq_a[1023], rq_b[1023], rq_k[1023]);
    else passed++;
`endif
    mism = 0; first = -1;
    for (int i = 0; i < n_exp && i < n_req; i++) begin
      model_req(1, i, ea, eb, ek, es);
      if (rq_a[i] != ea || rq_b[i] != eb || rq_k[i] != ek || rq_s[i] != es) begin
        mism++; if (first < 0) first = i;
      end
    end
    total++; if (mism !== 0) $display("FAIL intt_sequence: got %0d mismatches (first at %0d) expected 0", mism, first); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL intt_done_count: got %0d expected 1", done_cnt); else passed++;
  endtask

  task automatic test_max_outstanding();
    clear_rec(); auto_ret = 0; rdy_rand = 0; rdy_val = 1;
    do_start(0);
    repeat (20) @(negedge clk_i);
    total++; if (n_req !== 8) $display("FAIL maxout_issued: got %0d expected 8", n_req); else passed++;
    total++; if (bf_valid_o !== 1'b0 || busy_o !== 1'b1)
      $display("FAIL maxout_blocked: got valid=%b busy=%b expected 0 1", bf_valid_o, busy_o);
    else passed++;
    @(negedge clk_i); man_ret = 1;
    @(negedge clk_i); man_ret = 0;
    repeat (10) @(negedge clk_i);
    total++; if (n_req !== 9) $display("FAIL maxout_one_more: got %0d expected 9", n_req); else passed++;
    total++; if (bf_valid_o !== 1'b0) $display("FAIL maxout_reblocked: got %b expected 0", bf_valid_o); else passed++;
    do_abort();
    total++; if (busy_o !== 1'b0) $display("FAIL maxout_abort_idle: got busy=%b expected 0", busy_o); else passed++;
    repeat (4) @(negedge clk_i);
  endtask

  task automatic test_random_stalls();
    bit ok;
    int mism, first, ea, eb, ek;
    bit es;
    clear_rec(); auto_ret = 1; rdy_rand = 1;
    do_start(0);
    wait_done(8000, ok);
    rdy_rand = 0; rdy_val = 1;
    total++; if (ok !== 1'b1) $display("FAIL stall_done_timeout: got %b expected 1", ok); else passed++;
    total++; if (n_req !== 896) $display("FAIL stall_req_count: got %0d expected 896", n_req); else passed++;
    total++; if (stall_viol !== 0) $display("FAIL stall_hold: got %0d unstable stalled cycles expected 0", stall_viol); else passed++;
    mism = 0; first = -1;
    for (int i = 0; i < 896 && i < n_req; i++) begin
      model_req(0, i, ea, eb, ek, es);
      if (rq_a[i] != ea || rq_b[i] != eb || rq_k[i] != ek || rq_s[i] != es) begin
        mism++; if (first < 0) first = i;
      end
    end
    total++; if (mism !== 0) $display("FAIL stall_sequence: got %0d mismatches (first at %0d) expected 0", mism, first); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL stall_done_count: got %0d expected 1", done_cnt); else passed++;
  endtask

  task automatic test_abort();
    bit reached;
    int n_at;
    clear_rec(); auto_ret = 1; rdy_rand = 0; rdy_val = 1;
    do_start(0);
    reached = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_i);
      if (layer_o == 3'd3) begin reached = 1; break; end
    end
    total++; if (reached !== 1'b1) $display("FAIL abort_reach_layer3: got %b expected 1", reached); else passed++;
    repeat (5) @(negedge clk_i);
    do_abort();
    total++; if (busy_o !== 1'b0 || bf_valid_o !== 1'b0)
      $display("FAIL abort_idle: got busy=%b valid=%b expected 0 0", busy_o, bf_valid_o);
    else passed++;
    n_at = n_req;
    repeat (12) @(negedge clk_i);
    total++; if (err_o !== 1'b0) $display("FAIL abort_late_ret_err: got %b expected 0", err_o); else passed++;
    total++; if (done_cnt !== 0 || n_req !== n_at)
      $display("FAIL abort_quiet: got done=%0d reqs=%0d expected 0 %0d", done_cnt, n_req, n_at);
    else passed++;
    @(negedge clk_i); man_ret = 1;
    @(negedge clk_i); man_ret = 0;
    @(negedge clk_i);
    total++; if (err_o !== 1'b1) $display("FAIL spurious_ret_err: got %b expected 1", err_o); else passed++;
    @(negedge clk_i); abort_i = 1; start_i = 1; mode_i = 0;
    @(negedge clk_i); abort_i = 0; start_i = 0;
    total++; if (busy_o !== 1'b0 || err_o !== 1'b1)
      $display("FAIL abort_beats_start: got busy=%b err=%b expected 0 1", busy_o, err_o);
    else passed++;
    do_start(0);
    total++; if (err_o !== 1'b0 || busy_o !== 1'b1)
      $display("FAIL start_clears_err: got err=%b busy=%b expected 0 1", err_o, busy_o);
    else passed++;
    do_abort();
    repeat (12) @(negedge clk_i);
  endtask

  task automatic test_async_reset();
    clear_rec(); auto_ret = 1; rdy_rand = 0; rdy_val = 1;
    do_start(1);
    repeat (50) @(negedge clk_i);
    auto_ret = 0;
    #2 rst_ni = 0;
    #1;
    total++; if (busy_o !== 1'b0 || bf_valid_o !== 1'b0)
      $display("FAIL async_reset_immediate: got busy=%b valid=%b expected 0 0", busy_o, bf_valid_o);
    else passed++;
    @(negedge clk_i); rst_ni = 1;
    repeat (20) @(negedge clk_i);
    total++; if (done_cnt !== 0 || busy_o !== 1'b0)
      $display("FAIL async_reset_no_done: got done=%0d busy=%b expected 0 0", done_cnt, busy_o);
    else passed++;
  endtask

  initial begin
    clear_rec();
    test_reset();
    test_ntt();
    test_intt();
    test_max_outstanding();
    test_random_stalls();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
